// File: rtl/one_hot_mux_buf.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_mux_buf
// Description : One-hot select of CNT valid/ready producer channels into a
//               2-entry FIFO output buffer with a valid/ready consumer port.
//               Reports a sticky multi-hot-select error.
//               Optional macro ONE_HOT_MUX_BUF_PRIO_EN reduces the select to
//               its lowest set bit before every use; the error still sees
//               the raw select.
// Revision    : 1.0 - initial release
// ============================================================================
module one_hot_mux_buf #(
    parameter int WIDTH = 32,
    parameter int CNT   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH*CNT-1:0]  din,
    input  logic [CNT-1:0]        din_vld,
    output logic [CNT-1:0]        din_rdy,
    input  logic [CNT-1:0]        sel,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic [1:0]            occ,
    output logic                  err,
    input  logic                  err_clr
);

    localparam logic [CNT-1:0] c_one      = {{(CNT-1){1'b0}}, 1'b1};
    localparam logic [1:0]     c_occ_zero = 2'd0;
    localparam logic [1:0]     c_occ_one  = 2'd1;
    localparam logic [1:0]     c_occ_two  = 2'd2;

    logic [WIDTH-1:0] r_mem0;   // head entry, drives dout directly
    logic [WIDTH-1:0] r_mem1;   // second entry
    logic [1:0]       r_occ;
    logic             r_err;

    logic [CNT-1:0]   w_sel;
    logic [WIDTH-1:0] w_word;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_multi;
    logic             w_err_set;

`ifdef ONE_HOT_MUX_BUF_PRIO_EN
    // Lowest set bit of the select wins; two's-complement isolate.
    assign w_sel = sel & (~sel + c_one);
`else
    assign w_sel = sel;
`endif

    // More than one select bit set: clearing the lowest bit leaves a residue.
    assign w_multi   = |(sel & (sel - c_one));
    assign w_err_set = w_multi & (|(sel & din_vld));

    assign w_full   = (r_occ == c_occ_two);
    assign din_rdy  = w_sel & {CNT{~w_full}};
    assign w_push   = (|(w_sel & din_vld)) & ~w_full;
    assign dout_vld = (r_occ != c_occ_zero);
    assign w_pop    = dout_vld & dout_rdy;

    assign dout = r_mem0;
    assign occ  = r_occ;
    assign err  = r_err;

    // OR-combine every selected channel into the word to be pushed.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < CNT; k++) begin
            if (w_sel[k]) begin
                w_word = w_word | din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Two-entry FIFO: head stays in r_mem0 so dout never sees din combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= c_occ_zero;
        end else begin
            case (r_occ)
                c_occ_zero: begin
                    if (w_push) begin
                        r_mem0 <= w_word;
                        r_occ  <= c_occ_one;
                    end
                end
                c_occ_one: begin
                    if (w_push && w_pop) begin
                        r_mem0 <= w_word;
                    end else if (w_push) begin
                        r_mem1 <= w_word;
                        r_occ  <= c_occ_two;
                    end else if (w_pop) begin
                        // head keeps the popped word so dout holds it while empty
                        r_occ  <= c_occ_zero;
                    end
                end
                c_occ_two: begin
                    if (w_pop) begin
                        r_mem0 <= r_mem1;
                        r_occ  <= c_occ_one;
                    end
                end
                default: begin
                    r_occ <= c_occ_zero;
                end
            endcase
        end
    end

    // Sticky error: a new multi-hot request overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_one_hot_mux_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_one_hot_mux_buf
// Description : Self-checking bench for one_hot_mux_buf (WIDTH=8, CNT=4),
//               directed scenarios plus randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_hot_mux_buf;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [3:0]  din_vld;
    logic [3:0]  din_rdy;
    logic [3:0]  sel;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic [1:0]  occ;
    logic        err;
    logic        err_clr;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic [7:0] m_last;
    logic       m_err;

    one_hot_mux_buf #(.WIDTH(8), .CNT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .sel      (sel),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .occ      (occ),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Select as the model sees it: lowest set bit in priority builds.
    function automatic logic [3:0] eff_sel(input logic [3:0] s);
        logic [3:0] r;
        r = s;
`ifdef ONE_HOT_MUX_BUF_PRIO_EN
        r = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
            if (s[k]) r = 4'(1 << k);
        end
`endif
        return r;
    endfunction

    function automatic logic [7:0] exp_dout();
        return (q.size() > 0) ? q[0] : m_last;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_occ"},  32'(occ),      32'(q.size()));
        check({tag, "_vld"},  32'(dout_vld), 32'(q.size() > 0));
        check({tag, "_dout"}, 32'(dout),     32'(exp_dout()));
        check({tag, "_err"},  32'(err),      32'(m_err));
    endtask

    // One clock of traffic: drive at negedge, check ready, advance model at edge.
    task automatic cycle(input logic [3:0] s, input logic [3:0] v, input logic [31:0] d,
                         input logic r, input logic c);
        logic [3:0] se;
        logic [7:0] w;
        logic       push, pop, set;
        int         n;
        @(negedge clk);
        sel = s; din_vld = v; din = d; dout_rdy = r; err_clr = c;
        #1;
        se = eff_sel(s);
        n  = q.size();
        check("din_rdy", 32'(din_rdy), 32'((n == 2) ? 4'b0000 : se));
        w = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (se[k]) w = w | d[k*8 +: 8];
        end
        push = (|(se & v)) && (n < 2);
        pop  = (n > 0) && r;
        set  = ($countones(s) > 1) && (|(s & v));
        @(posedge clk);
        if (pop)  m_last = q.pop_front();
        if (push) q.push_back(w);
        m_err = set ? 1'b1 : (c ? 1'b0 : m_err);
        #1;
        check_outputs("cyc");
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 8'h00;
        m_err  = 1'b0;
    endtask

    initial begin
        logic [3:0] s;
        int         r0;

        rst_n = 1'b0; sel = 4'b0; din_vld = 4'b0; din = 32'h0; dout_rdy = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("reset");
        check("reset_din_rdy", 32'(din_rdy), 32'h0);

        // Latency and back-to-back throughput on channel 2
        cycle(4'b0100, 4'b0100, 32'h00A5_0000, 1'b1, 1'b0);
        check("lat_dout", 32'(dout), 32'hA5);
        check("lat_vld",  32'(dout_vld), 32'h1);
        cycle(4'b0100, 4'b0100, 32'h005A_0000, 1'b1, 1'b0);
        check("b2b_dout", 32'(dout), 32'h5A);
        cycle(4'b0100, 4'b0100, 32'h003C_0000, 1'b1, 1'b0);
        check("b2b_occ", 32'(occ), 32'h1);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0);

        // Stall: fill to two entries, third word is held off
        cycle(4'b0001, 4'b0001, 32'h0000_0011, 1'b0, 1'b0);
        cycle(4'b0001, 4'b0001, 32'h0000_0022, 1'b0, 1'b0);
        check("stall_occ", 32'(occ), 32'h2);
        cycle(4'b0001, 4'b0001, 32'h0000_0033, 1'b0, 1'b0);
        check("stall_head", 32'(dout), 32'h11);
        cycle(4'b0001, 4'b0001, 32'h0000_0033, 1'b1, 1'b0);
        check("drain1", 32'(dout), 32'h22);
        cycle(4'b0001, 4'b0001, 32'h0000_0033, 1'b1, 1'b0);
        check("pushpop_occ", 32'(occ), 32'h1);
        check("drain2", 32'(dout), 32'h33);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0);
        check("empty_hold", 32'(dout), 32'h33);

        // Multi-hot select on channels 0 and 1
        cycle(4'b0011, 4'b0011, 32'h0000_0FF0, 1'b1, 1'b0);
        check("multi_err", 32'(err), 32'h1);
`ifdef ONE_HOT_MUX_BUF_PRIO_EN
        check("multi_dout", 32'(dout), 32'hF0);
`else
        check("multi_dout", 32'(dout), 32'hFF);
`endif
        cycle(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b1);
        check("clr_err", 32'(err), 32'h0);
        cycle(4'b0011, 4'b0011, 32'h0000_0FF0, 1'b1, 1'b1);
        check("set_wins", 32'(err), 32'h1);

        // sel=0 with every channel valid: nothing moves
        cycle(4'b0000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cycle(4'b0000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Fill, then asynchronous reset mid-stream with err set
        cycle(4'b1000, 4'b1000, 32'h7700_0000, 1'b0, 1'b0);
        cycle(4'b1000, 4'b1000, 32'h6600_0000, 1'b0, 1'b0);
        check("prerst_occ", 32'(occ), 32'h2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sel = 4'b0001; din_vld = 4'b0001; din = 32'h0000_0099; dout_rdy = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check("rst_hold_occ", 32'(occ), 32'h0);
        @(negedge clk);
        sel = 4'b0000; din_vld = 4'b0000;
        rst_n = 1'b1;
        cycle(4'b0001, 4'b0001, 32'h0000_0099, 1'b1, 1'b0);
        check("post_rst_dout", 32'(dout), 32'h99);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r0 = $urandom_range(0, 99);
            if (r0 < 15)      s = 4'b0000;
            else if (r0 < 75) s = 4'(1 << $urandom_range(0, 3));
            else              s = 4'($urandom);
            cycle(s, 4'($urandom), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
